// File: rtl/tod_frame_rx.sv
// Time-of-day frame receiver.
// Parses a byte stream of sync/class/ID/payload/checksum frames. Time and status payload fields
// are captured into shadow registers. A frame whose XOR checksum matches is committed. Each
// synchronised PPS rising edge then publishes the committed time. If no fresh frame has arrived,
// the published time free-runs in holdover instead.
// Ports:
//   clk_125m_i, rst_n          - single clock, asynchronous active-low reset
//   pps_i                      - asynchronous PPS, rising edge used
//   din_i / din_vld_i          - byte stream with one-cycle qualifier
//   week_o, week_sec_o         - published GPS week / second-of-week
//   leap_sec_o, pps_state_o,
//   pps_precision_o,
//   timesrc_type_o             - published auxiliary fields
//   tod_valid_o, holdover_o    - time validity / holdover indication
//   frame_ok_o, frame_err_o    - one-cycle pulses per accepted / rejected frame
//   chk_err_cnt_o              - saturating checksum-error count
module tod_frame_rx #(
  parameter logic [7:0]  SYNC0    = 8'h43,
  parameter logic [7:0]  SYNC1    = 8'h4D,
  parameter logic [7:0]  CLS      = 8'h01,
  parameter logic [7:0]  ID_TIME  = 8'h20,
  parameter logic [7:0]  ID_STAT  = 8'h03,
  parameter int unsigned MSG_LEN  = 19,
  parameter int unsigned BYTE_TO  = 12500,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk_125m_i,
  input  logic        rst_n,
  input  logic        pps_i,
  input  logic [7:0]  din_i,
  input  logic        din_vld_i,
  output logic [15:0] week_o,
  output logic [31:0] week_sec_o,
  output logic [7:0]  leap_sec_o,
  output logic [7:0]  pps_state_o,
  output logic [7:0]  pps_precision_o,
  output logic [7:0]  timesrc_type_o,
  output logic        tod_valid_o,
  output logic        holdover_o,
  output logic        frame_ok_o,
  output logic        frame_err_o,
  output logic [15:0] chk_err_cnt_o
);

  localparam logic [31:0] SecMax  = 32'd604799;
  localparam logic [7:0]  LastIdx = 8'(MSG_LEN - 1);
  localparam int unsigned WdW     = $clog2(BYTE_TO + 1);

  typedef enum logic [2:0] {StIdle, StS1, StCl, StId, StPayT, StPayS} state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     chk_q, chk_d;
  logic [WdW-1:0] wd_q, wd_d;

  // Shadow (in-flight) fields
  logic [31:0] sh_sec_q, sh_sec_d;
  logic [15:0] sh_week_q, sh_week_d;
  logic [7:0]  sh_leap_q, sh_leap_d, sh_pst_q, sh_pst_d, sh_prec_q, sh_prec_d, sh_ts_q, sh_ts_d;

  // Committed fields
  logic [31:0] c_sec_q, c_sec_d;
  logic [15:0] c_week_q, c_week_d;
  logic [7:0]  c_leap_q, c_leap_d, c_pst_q, c_pst_d, c_prec_q, c_prec_d, c_ts_q, c_ts_d;

  logic        commit_t_q, commit_t_d, commit_s_q, commit_s_d;
  logic        fresh_q, fresh_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;

  // Published outputs
  logic [15:0] week_q, week_d, err_cnt_q, err_cnt_d;
  logic [31:0] week_sec_q, week_sec_d;
  logic [7:0]  leap_q, leap_d, pst_q, pst_d, prec_q, prec_d, ts_q, ts_d;
  logic        tod_valid_q, tod_valid_d, holdover_q, holdover_d;
  logic        frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;

  logic pps_meta_q, pps_sync_q, pps_dly_q, pps_l2h;

  assign pps_l2h = pps_sync_q & ~pps_dly_q;

  // Frame parser
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    wd_d        = wd_q;
    sh_sec_d    = sh_sec_q;
    sh_week_d   = sh_week_q;
    sh_leap_d   = sh_leap_q;
    sh_pst_d    = sh_pst_q;
    sh_prec_d   = sh_prec_q;
    sh_ts_d     = sh_ts_q;
    commit_t_d  = 1'b0;
    commit_s_d  = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    // Inter-byte watchdog; a timeout abandons the frame without touching the error count.
    if (state_q == StIdle || din_vld_i) begin
      wd_d = '0;
    end else if (wd_q == WdW'(BYTE_TO - 1)) begin
      wd_d        = '0;
      state_d     = StIdle;
      frame_err_d = 1'b1;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    if (din_vld_i) begin
      unique case (state_q)
        StIdle: if (din_i == SYNC0) state_d = StS1;
        StS1:   state_d = (din_i == SYNC1) ? StCl : StIdle;
        StCl: begin
          if (din_i == CLS) begin
            state_d = StId;
            chk_d   = din_i;
          end else begin
            state_d = StIdle;
          end
        end
        StId: begin
          cnt_d = '0;
          chk_d = chk_q ^ din_i;
          if (din_i == ID_TIME)      state_d = StPayT;
          else if (din_i == ID_STAT) state_d = StPayS;
          else                       state_d = StIdle;
        end
        StPayT, StPayS: begin
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
            if (din_i == chk_q) begin
              frame_ok_d = 1'b1;
              commit_t_d = (state_q == StPayT);
              commit_s_d = (state_q == StPayS);
            end else begin
              frame_err_d = 1'b1;
              if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end
          end else begin
            chk_d = chk_q ^ din_i;
            cnt_d = cnt_q + 8'd1;
          end
          if (state_q == StPayT) begin
            case (cnt_q)
              8'd2:    sh_sec_d[31:24] = din_i;
              8'd3:    sh_sec_d[23:16] = din_i;
              8'd4:    sh_sec_d[15:8]  = din_i;
              8'd5:    sh_sec_d[7:0]   = din_i;
              8'd10:   sh_week_d[15:8] = din_i;
              8'd11:   sh_week_d[7:0]  = din_i;
              8'd12:   sh_leap_d       = din_i;
              8'd13:   sh_pst_d        = din_i;
              8'd14:   sh_prec_d       = din_i;
              default: ;
            endcase
          end else if (cnt_q == 8'd2) begin
            sh_ts_d = din_i;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Commit and PPS publication. A PPS coinciding with a commit sees the pre-commit values.
  always_comb begin
    c_sec_d     = c_sec_q;
    c_week_d    = c_week_q;
    c_leap_d    = c_leap_q;
    c_pst_d     = c_pst_q;
    c_prec_d    = c_prec_q;
    c_ts_d      = c_ts_q;
    fresh_d     = fresh_q;
    hold_cnt_d  = hold_cnt_q;
    week_d      = week_q;
    week_sec_d  = week_sec_q;
    leap_d      = leap_q;
    pst_d       = pst_q;
    prec_d      = prec_q;
    ts_d        = ts_q;
    tod_valid_d = tod_valid_q;
    holdover_d  = holdover_q;

    if (commit_t_q) begin
      c_sec_d  = sh_sec_q;
      c_week_d = sh_week_q;
      c_leap_d = sh_leap_q;
      c_pst_d  = sh_pst_q;
      c_prec_d = sh_prec_q;
    end
    if (commit_s_q) c_ts_d = sh_ts_q;

    if (pps_l2h) begin
      fresh_d = 1'b0;
      leap_d  = c_leap_q;
      pst_d   = c_pst_q;
      prec_d  = c_prec_q;
      ts_d    = c_ts_q;
      if (fresh_q) begin
        if (c_sec_q == SecMax) begin
          week_sec_d = '0;
          week_d     = c_week_q + 16'd1;
        end else begin
          week_sec_d = c_sec_q + 32'd1;
          week_d     = c_week_q;
        end
        hold_cnt_d  = '0;
        holdover_d  = 1'b0;
        tod_valid_d = 1'b1;
      end else begin
        if (week_sec_q == SecMax) begin
          week_sec_d = '0;
          week_d     = week_q + 16'd1;
        end else begin
          week_sec_d = week_sec_q + 32'd1;
        end
        holdover_d = 1'b1;
        if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
        if (32'(hold_cnt_d) > HOLD_MAX) tod_valid_d = 1'b0;
      end
    end
    if (commit_t_q) fresh_d = 1'b1;
  end

  always_ff @(posedge clk_125m_i or negedge rst_n) begin
    if (!rst_n) begin
      pps_meta_q  <= 1'b0;
      pps_sync_q  <= 1'b0;
      pps_dly_q   <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      chk_q       <= '0;
      wd_q        <= '0;
      sh_sec_q    <= '0;
      sh_week_q   <= '0;
      sh_leap_q   <= '0;
      sh_pst_q    <= '0;
      sh_prec_q   <= '0;
      sh_ts_q     <= '0;
      c_sec_q     <= '0;
      c_week_q    <= '0;
      c_leap_q    <= '0;
      c_pst_q     <= '0;
      c_prec_q    <= '0;
      c_ts_q      <= '0;
      commit_t_q  <= 1'b0;
      commit_s_q  <= 1'b0;
      fresh_q     <= 1'b0;
      hold_cnt_q  <= '0;
      week_q      <= '0;
      week_sec_q  <= '0;
      leap_q      <= '0;
      pst_q       <= '0;
      prec_q      <= '0;
      ts_q        <= '0;
      tod_valid_q <= 1'b0;
      holdover_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pps_meta_q  <= pps_i;
      pps_sync_q  <= pps_meta_q;
      pps_dly_q   <= pps_sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      wd_q        <= wd_d;
      sh_sec_q    <= sh_sec_d;
      sh_week_q   <= sh_week_d;
      sh_leap_q   <= sh_leap_d;
      sh_pst_q    <= sh_pst_d;
      sh_prec_q   <= sh_prec_d;
      sh_ts_q     <= sh_ts_d;
      c_sec_q     <= c_sec_d;
      c_week_q    <= c_week_d;
      c_leap_q    <= c_leap_d;
      c_pst_q     <= c_pst_d;
      c_prec_q    <= c_prec_d;
      c_ts_q      <= c_ts_d;
      commit_t_q  <= commit_t_d;
      commit_s_q  <= commit_s_d;
      fresh_q     <= fresh_d;
      hold_cnt_q  <= hold_cnt_d;
      week_q      <= week_d;
      week_sec_q  <= week_sec_d;
      leap_q      <= leap_d;
      pst_q       <= pst_d;
      prec_q      <= prec_d;
      ts_q        <= ts_d;
      tod_valid_q <= tod_valid_d;
      holdover_q  <= holdover_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign week_o          = week_q;
  assign week_sec_o      = week_sec_q;
  assign leap_sec_o      = leap_q;
  assign pps_state_o     = pst_q;
  assign pps_precision_o = prec_q;
  assign timesrc_type_o  = ts_q;
  assign tod_valid_o     = tod_valid_q;
  assign holdover_o      = holdover_q;
  assign frame_ok_o      = frame_ok_q;
  assign frame_err_o     = frame_err_q;
  assign chk_err_cnt_o   = err_cnt_q;

endmodule

// File: doc/tod_frame_rx.md
TOD_FRAME_RX -- requirements
Module: tod_frame_rx

Interface
REQ-001 Parameter SYNC0, default 8'h43, meaning first sync byte.
REQ-002 Parameter SYNC1, default 8'h4D, meaning second sync byte.
REQ-003 Parameter CLS, default 8'h01, meaning class byte.
REQ-004 Parameter ID_TIME, default 8'h20, meaning time-message ID; ID_STAT, default 8'h03, meaning status-message ID.
REQ-005 Parameter MSG_LEN, default 19, range 16..255, meaning payload bytes after ID; the last payload byte is the checksum.
REQ-006 Parameter BYTE_TO, default 12500, meaning the maximum clk_125m cycles allowed between bytes inside a frame.
REQ-007 Parameter HOLD_MAX, default 8, meaning the number of PPS edges allowed without a fresh time frame before tod_valid drops.
REQ-008 clk_125m  in  1  system clock; one clock and one clock domain only.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 pps  in  1  asynchronous PPS input; rising edge is used.
REQ-011 din / din_vld  in  8 / 1  byte stream with a one-cycle qualifier.
REQ-012 week  out  16; week_sec  out  32; leap_sec, pps_state, pps_precision, timesrc_type  out  8 each.
REQ-013 tod_valid  out  1; holdover  out  1; frame_ok  out  1 (pulse); frame_err  out  1 (pulse); chk_err_cnt  out  16.

Function
REQ-014 pps shall pass through a 2-flop synchroniser; pps_l2h shall be asserted when the second flop is 1 and the third flop is 0, giving 3 cycles of latency from the input edge.
REQ-015 The FSM shall have states IDLE, S1, CL, ID, PAY_T, PAY_S.
- IDLE -> S1 on a byte equal to SYNC0.
- S1 -> CL on SYNC1; CL -> ID on CLS.
- ID -> PAY_T on ID_TIME; ID -> PAY_S on ID_STAT.
- Any other valid byte in S1/CL/ID -> IDLE.
REQ-016 In PAY_T and PAY_S, a byte counter (0..MSG_LEN-1) shall advance on each din_vld; the state shall return to IDLE on the byte at index MSG_LEN-1.
REQ-017 The running checksum shall be the XOR of the CLS byte, the ID byte and payload bytes 0..MSG_LEN-2; it shall be compared with payload byte MSG_LEN-1.
REQ-018 Time-payload fields shall be captured into shadow registers:
- week_sec: bytes 2..5, big-endian.
- week: bytes 10..11, big-endian.
- leap: byte 12; pps_state: byte 13; precision: byte 14.
REQ-019 Status-payload field: timesrc_type shall be captured from byte 2.
REQ-020 Shadow registers shall be copied into committed registers only in the cycle after a checksum match; on a match, frame_ok shall pulse for 1 cycle.
REQ-021 On a checksum mismatch, frame_err shall pulse, chk_err_cnt shall increment and saturate at 16'hFFFF, and the committed registers shall be unchanged.
REQ-022 Byte timeout: a watchdog in any state other than IDLE shall reset on each din_vld.
- When it reaches BYTE_TO: the state shall go to IDLE, frame_err shall pulse, and chk_err_cnt shall be unchanged.
- After a timeout, partial shadow data shall never be committed.
REQ-023 A fresh flag shall be set on a time-frame commit and cleared on pps_l2h.
- If a commit and pps_l2h coincide, pps_l2h shall use the pre-commit committed values and the old fresh flag, and fresh shall end set.
REQ-024 On pps_l2h with fresh=1:
- week_sec = committed_sec+1 and week = committed_week.
- If committed_sec == 604799: week_sec = 0 and week = committed_week+1, wrapping at 16 bits.
- The holdover counter shall clear, holdover shall be 0 and tod_valid shall be 1.
REQ-025 On pps_l2h with fresh=0:
- week_sec = week_sec+1, and week shall increment when week_sec wraps from 604799 to 0.
- holdover shall be 1, and the holdover counter (8-bit) shall increment, saturating at 255.
- tod_valid shall be 0 once the counter exceeds HOLD_MAX.
REQ-026 On every pps_l2h, leap_sec, pps_state, pps_precision and timesrc_type shall load from their committed registers.
REQ-027 All registered outputs shall update exactly 1 cycle after pps_l2h; there shall be no output change between PPS edges except frame_ok, frame_err and chk_err_cnt.
REQ-028 Bytes arriving in IDLE that are not SYNC0 shall be ignored.
REQ-029 A SYNC0 byte arriving mid-frame shall be treated as payload, with no resync.

Reset
REQ-030 rst_n low shall immediately reset all state, counters, shadow registers, committed registers and outputs to 0, holdover and tod_valid included.
REQ-031 The FSM shall enter IDLE on reset; a frame in progress when reset is asserted shall be discarded.
REQ-032 After reset release, tod_valid shall stay 0 until the first PPS following a good time frame.

Verification
REQ-033 Good time frame with week_sec=100 and week=2300, then a PPS -> week_sec=101, week=2300, tod_valid=1, frame_ok pulsed once.
REQ-034 Time frame with week_sec=604799 and week=65535, then a PPS -> week_sec=0, week=0.
REQ-035 Frame with a corrupted checksum byte -> frame_err pulses, chk_err_cnt=1, committed values unchanged at the next PPS.
REQ-036 Stall of 12500 cycles after payload byte 7, then a full good frame -> first frame dropped with a frame_err pulse, second frame committed.
REQ-037 Good frame followed by 10 PPS edges and no further frames -> week_sec increments by 10; holdover=1 from the 2nd PPS; tod_valid=0 from the 10th PPS.
REQ-038 Commit and pps_l2h in the same cycle, then a second PPS -> the first PPS applies the old data, the second applies the new data with fresh=1.
